// File: rtl/vga_rect_filler_if.sv
// Command and pixel-stream bundle for the rectangle fill engine.
// The engine is the master: it consumes commands and drives the pixel
// write requests toward video memory. The slave side issues commands
// and answers each pixel with plot_ready.
interface vga_rect_filler_if #(
    parameter int X_BITS     = 9,
    parameter int Y_BITS     = 8,
    parameter int COLOR_BITS = 3
);
    logic                  start;
    logic [X_BITS-1:0]     x0;
    logic [Y_BITS-1:0]     y0;
    logic [X_BITS-1:0]     width;
    logic [Y_BITS-1:0]     height;
    logic [COLOR_BITS-1:0] color;
    logic                  busy;
    logic                  done;
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic [COLOR_BITS-1:0] colour;
    logic                  plot;
    logic                  plot_ready;

    modport master (
        input  start, x0, y0, width, height, color, plot_ready,
        output busy, done, x, y, colour, plot
    );

    modport slave (
        output start, x0, y0, width, height, color, plot_ready,
        input  busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: turns one (origin, size, colour) command into a
// row-major stream of pixel writes, clipped to the visible dot space.
// Pixels leave through a valid/ready handshake (plot / plot_ready).
module vga_rect_filler #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int X_BITS     = 9,
    parameter int Y_BITS     = 8,
    parameter int COLOR_BITS = 3
) (
    input logic               clock,
    input logic               reset,
    vga_rect_filler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  plot_r;
    logic [X_BITS-1:0]     x_r;
    logic [Y_BITS-1:0]     y_r;
    logic [COLOR_BITS-1:0] colour_r;
    logic [X_BITS-1:0]     x_start_r;
    logic [X_BITS-1:0]     x_last_r;
    logic [Y_BITS-1:0]     y_last_r;

    // Clipped extents are formed in 10 bits so SCREEN - origin never wraps.
    logic [9:0] x0_ext_s;
    logic [9:0] y0_ext_s;
    logic [9:0] w_ext_s;
    logic [9:0] h_ext_s;
    logic [9:0] avail_w_s;
    logic [9:0] avail_h_s;
    logic [9:0] ew_s;
    logic [9:0] eh_s;
    logic [9:0] x_last_s;
    logic [9:0] y_last_s;

    // Clip the requested width/height against the screen edge.
    always_comb begin
        x0_ext_s  = 10'(bus.x0);
        y0_ext_s  = 10'(bus.y0);
        w_ext_s   = 10'(bus.width);
        h_ext_s   = 10'(bus.height);
        avail_w_s = 10'(SCREEN_W) - x0_ext_s;
        avail_h_s = 10'(SCREEN_H) - y0_ext_s;
        ew_s      = 10'd0;
        eh_s      = 10'd0;
        if (x0_ext_s >= 10'(SCREEN_W)) begin
            ew_s = 10'd0;
        end else if (w_ext_s < avail_w_s) begin
            ew_s = w_ext_s;
        end else begin
            ew_s = avail_w_s;
        end
        if (y0_ext_s >= 10'(SCREEN_H)) begin
            eh_s = 10'd0;
        end else if (h_ext_s < avail_h_s) begin
            eh_s = h_ext_s;
        end else begin
            eh_s = avail_h_s;
        end
        // Only meaningful when the extents are non-zero.
        x_last_s = x0_ext_s + ew_s - 10'd1;
        y_last_s = y0_ext_s + eh_s - 10'd1;
    end

    // Command FSM and registered pixel outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            plot_r    <= 1'b0;
            x_r       <= {X_BITS{1'b0}};
            y_r       <= {Y_BITS{1'b0}};
            colour_r  <= {COLOR_BITS{1'b0}};
            x_start_r <= {X_BITS{1'b0}};
            x_last_r  <= {X_BITS{1'b0}};
            y_last_r  <= {Y_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if ((ew_s == 10'd0) || (eh_s == 10'd0)) begin
                            state_r <= FINISH;
                        end else begin
                            state_r   <= DRAW;
                            x_r       <= bus.x0;
                            y_r       <= bus.y0;
                            colour_r  <= bus.color;
                            plot_r    <= 1'b1;
                            x_start_r <= bus.x0;
                            x_last_r  <= X_BITS'(x_last_s);
                            y_last_r  <= Y_BITS'(y_last_s);
                        end
                    end
                end
                DRAW: begin
                    // Outputs only move on a completed transfer.
                    if (plot_r && bus.plot_ready) begin
                        if (x_r == x_last_r) begin
                            if (y_r == y_last_r) begin
                                plot_r  <= 1'b0;
                                state_r <= FINISH;
                            end else begin
                                x_r <= x_start_r;
                                y_r <= y_r + {{(Y_BITS-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            x_r <= x_r + {{(X_BITS-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FINISH: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    plot_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.plot   = plot_r;
    assign bus.x      = x_r;
    assign bus.y      = y_r;
    assign bus.colour = colour_r;
endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for the rectangle fill engine.
module tb_vga_rect_filler;
    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    vga_rect_filler_if #(.X_BITS(9), .Y_BITS(8), .COLOR_BITS(3)) vif ();

    vga_rect_filler dut (
        .clock (clock),
        .reset (reset),
        .bus   (vif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [19:0] pix_q[$];
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] px(input int xx, input int yy, input int cc);
        return {cc[2:0], yy[7:0], xx[8:0]};
    endfunction

    function automatic logic [19:0] cur();
        return {vif.colour, vif.y, vif.x};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input int x0, input int y0, input int w, input int h, input int c);
        vif.x0     = 9'(x0);
        vif.y0     = 8'(y0);
        vif.width  = 9'(w);
        vif.height = 8'(h);
        vif.color  = 3'(c);
    endtask

    // Issue a command, collect transfers until done; mode 1 = ready 1,0,0,1 pattern.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int c,
                           input int mode, output int cyc, output int busy_cnt);
        logic [19:0] prev;
        logic        hold;
        logic        pr;
        int          k;
        pix_q.delete();
        set_cmd(x0, y0, w, h, c);
        vif.start      = 1'b1;
        vif.plot_ready = 1'b1;
        tick();
        vif.start = 1'b0;
        set_cmd(511, 255, 511, 255, 7);  // inputs after acceptance must be ignored
        cyc      = 1;
        busy_cnt = 0;
        hold     = 1'b0;
        prev     = 20'd0;
        k        = 0;
        while (vif.done !== 1'b1 && cyc < 200) begin
            if (hold) check("hold_stable", cur(), prev);
            if (vif.busy === 1'b1) busy_cnt++;
            pr = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            k++;
            vif.plot_ready = pr;
            if (vif.plot === 1'b1 && pr) pix_q.push_back(cur());
            hold = (vif.plot === 1'b1) && !pr;
            prev = cur();
            tick();
            cyc++;
        end
        vif.plot_ready = 1'b1;
        check("done_seen", vif.done, 1);
        check("busy_low_at_done", vif.busy, 0);
    endtask

    task automatic check_pixels(input string tag);
        check({tag, "_count"}, pix_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++)
            check({tag, "_pixel"}, pix_q[i], exp_q[i]);
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int bad;
        int done_cnt;
        tests_run    = 0;
        tests_failed = 0;
        reset          = 1'b1;
        vif.start      = 1'b0;
        vif.plot_ready = 1'b1;
        set_cmd(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_busy", vif.busy, 0);
        check("rst_done", vif.done, 0);
        check("rst_plot", vif.plot, 0);
        check("rst_xyc", cur(), 0);
        reset = 1'b0;
        tick();

        // Basic fill, first plot one cycle after start, start->done = 8.
        exp_q = '{px(10,20,4), px(11,20,4), px(12,20,4), px(10,21,4), px(11,21,4), px(12,21,4)};
        run_cmd(10, 20, 3, 2, 4, 0, cyc, busy_cnt);
        check_pixels("basic");
        check("basic_cycles", cyc, 8);
        check("basic_busy_cycles", busy_cnt, 7);
        tick();
        check("done_one_cycle", vif.done, 0);

        // Backpressure with ready 1,0,0,1,...
        run_cmd(10, 20, 3, 2, 4, 1, cyc, busy_cnt);
        check_pixels("bp");
        tick();

        // Clipping at the bottom-right corner.
        exp_q = '{px(318,238,1), px(319,238,1), px(318,239,1), px(319,239,1)};
        run_cmd(318, 238, 5, 5, 1, 0, cyc, busy_cnt);
        check_pixels("clip");
        check("clip_cycles", cyc, 6);
        tick();

        // Off-screen origin and zero width: no plots, done 2 cycles after start.
        exp_q.delete();
        run_cmd(320, 0, 4, 4, 6, 0, cyc, busy_cnt);
        check_pixels("offscreen");
        check("offscreen_cycles", cyc, 2);
        check("offscreen_busy", busy_cnt, 1);
        tick();
        run_cmd(10, 10, 0, 4, 6, 0, cyc, busy_cnt);
        check_pixels("zero_w");
        check("zero_w_cycles", cyc, 2);
        check("zero_w_busy", busy_cnt, 1);

        // Back-to-back: start during the done cycle.
        set_cmd(5, 5, 1, 1, 1);
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        check("b2b_plot", vif.plot, 1);
        check("b2b_pixel", cur(), px(5,5,1));
        check("b2b_busy", vif.busy, 1);
        check("b2b_done_low", vif.done, 0);
        tick();
        check("b2b_plot_end", vif.plot, 0);
        tick();
        check("b2b_done", vif.done, 1);
        tick();

        // Full-screen fill; ignored start at pixel 100; reset at pixel 500.
        set_cmd(0, 0, 320, 240, 2);
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
        bad      = 0;
        done_cnt = 0;
        for (int k = 0; k < 500; k++) begin
            if (vif.plot !== 1'b1 || cur() !== px(k % 320, k / 320, 2)) bad++;
            if (vif.done === 1'b1) done_cnt++;
            if (k == 100) begin
                set_cmd(50, 60, 2, 2, 5);
                vif.start = 1'b1;
            end else begin
                vif.start = 1'b0;
            end
            tick();
        end
        vif.start = 1'b0;
        check("full_order_errors", bad, 0);
        check("full_no_done", done_cnt, 0);
        check("full_pixel_500", cur(), px(500 % 320, 500 / 320, 2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_plot", vif.plot, 0);
        check("abort_busy", vif.busy, 0);
        check("abort_done", vif.done, 0);
        check("abort_xy", {vif.y, vif.x}, 0);
        tick();
        check("abort_no_done", vif.done, 0);

        // New command after reset is accepted normally.
        exp_q = '{px(7,9,7), px(8,9,7)};
        run_cmd(7, 9, 2, 1, 7, 0, cyc, busy_cnt);
        check_pixels("after_reset");
        check("after_reset_cycles", cyc, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/vga_rect_filler.md
Name: vga_rect_filler

Overview:
- Drawing engine upstream of video memory and the VGA controller's scan-out path.
- Accepts a rectangle command (origin, size, colour) and emits one pixel write per accepted cycle, in row-major order, into the 320x240 dot space.
- Its x/y/colour/plot outputs feed the video-memory write port through the address translator.
- Used for clearing the screen, maze walls and sprite background boxes.

Parameters:
- SCREEN_W, 320, visible dot columns; clip limit for x.
- SCREEN_H, 240, visible dot rows; clip limit for y.
- X_BITS, 9, width of x coordinate and rectangle width.
- Y_BITS, 8, width of y coordinate and rectangle height.
- COLOR_BITS, 3, pixel colour width (1 bit per RGB channel).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- x0  in  X_BITS  rectangle origin column.
- y0  in  Y_BITS  rectangle origin row.
- width  in  X_BITS  rectangle width in dots (0 allowed).
- height  in  Y_BITS  rectangle height in dots (0 allowed).
- color  in  COLOR_BITS  fill colour.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command finishes.
- x  out  X_BITS  current pixel column.
- y  out  Y_BITS  current pixel row.
- colour  out  COLOR_BITS  current pixel colour.
- plot  out  1  pixel valid (write request).
- plot_ready  in  1  memory side accepts the pixel this cycle.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, plot=0, x=0, y=0, colour=0. The FSM returns to IDLE.
- Reset mid-command aborts the command immediately. No done pulse is produced.
- FSM states: IDLE, DRAW, FINISH.
- IDLE, start=1: latch x0, y0 and color. Compute clipped extents in 10-bit arithmetic:
  - ew = min(width, SCREEN_W-x0), or 0 if x0>=SCREEN_W.
  - eh = min(height, SCREEN_H-y0), or 0 if y0>=SCREEN_H.
  - Set busy=1 on the next edge.
- If ew=0 or eh=0, go to FINISH. No plot is ever asserted.
- Otherwise go to DRAW. On that same edge: x=x0, y=y0, colour=color, plot=1. The first pixel is valid 1 cycle after start.
- DRAW uses a valid/ready handshake:
  - A pixel is transferred on a cycle where plot=1 and plot_ready=1.
  - While plot_ready=0, x, y, colour and plot are held stable.
- On transfer, advance x. When x = x0+ew-1, wrap x to x0 and increment y.
- The last pixel is (x0+ew-1, y0+eh-1). When it transfers: plot=0 on the next edge and the FSM goes to FINISH.
- FINISH lasts one cycle: done=1, busy=0 on the following edge, then back to IDLE.
- done is high for exactly 1 cycle. busy falls on the same edge that done rises.
- start while busy=1 or in FINISH is ignored, and nothing is queued.
- start in the same cycle done is high (FSM in IDLE) is accepted.
- The command inputs are sampled only on the accepting edge. Later changes have no effect.
- With plot_ready held high, total cycles from start to the done pulse = ew*eh + 2.
- x+1 and y+1 never exceed SCREEN_W-1 / SCREEN_H-1, because of the clipping. No wrap past the screen edge.

Test Plan:
- Basic fill: x0=10, y0=20, w=3, h=2, color=3'b100, plot_ready=1.
  -> 6 plots in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all with colour 100.
  -> The first plot is 1 cycle after start; done pulses 2 cycles after the start of the 6th-plot cycle… specifically start->done = 8 cycles.
- Backpressure: same command, plot_ready toggling 1,0,0,1,...
  -> Each pixel is held stable while ready=0. Exactly 6 transfers, no duplicates or skips. done follows the last transfer.
- Clipping: x0=318, y0=238, w=5, h=5.
  -> 4 plots: (318,238),(319,238),(318,239),(319,239). done after them.
- Off-screen and empty: x0=320, w=4, h=4, then a second command with w=0.
  -> No plot asserted in either case. Each gives a done pulse 2 cycles after start. busy is high for 1 cycle.
- Ignored start and reset abort: full-screen fill (0,0,320,240).
  -> A second start at pixel 100 is ignored; pixel order continues unchanged.
  -> reset asserted at pixel 500 gives plot=0, busy=0, x=y=0 next edge, with no done.
  -> A new start after reset is accepted normally.
- Back-to-back: start asserted in the done cycle with a 1x1 rectangle at (5,5).
  -> It is accepted. A single plot at (5,5) occurs 1 cycle later.
